// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: fixed-latency mult/div sequencing, HI/LO
// architectural registers, hazard/stall indication and mfhi/mflo read mux.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUop,
  input  logic        start,
  input  logic        flush,
  input  logic        rd_hi,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]  state_r;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] pending_hi_r;
  logic [31:0] pending_lo_r;
  logic        pending_wr_r;
  logic        accept_s;
  logic        is_md_s;
  logic [64:0] result_s;

  // Result packed as {write_enable, hi, lo}; divide by zero clears write_enable
  // so HI/LO keep their old contents at commit.
  function automatic logic [64:0] md_result(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sp = 64'sd0;
    up = 64'd0;
    sq = 32'sd0;
    sr = 32'sd0;
    md_result = {1'b0, 64'd0};
    case (op)
      OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        md_result = {1'b1, sp};
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        md_result = {1'b1, up};
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          md_result = {1'b0, 64'd0};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          md_result = {1'b1, 32'd0, 32'h8000_0000};
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          md_result = {1'b1, sr, sq};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          md_result = {1'b0, 64'd0};
        end else begin
          md_result = {1'b1, a % b, a / b};
        end
      end
      default: md_result = {1'b0, 64'd0};
    endcase
  endfunction

  // Issue qualification, stall indication and the mfhi/mflo read mux.
  always_comb begin
    busy      = (state_r == RUN);
    is_md_s   = (MDUop >= OP_MULT) && (MDUop <= OP_DIVU);
    accept_s  = start & ~flush & ~busy;
    md_hazard = busy | (start & is_md_s & ~flush);
    result_s  = md_result(MDUop, A, B);
    if (rd_hi) begin
      MDUout = hi_r;
    end else begin
      MDUout = lo_r;
    end
  end

  assign HI = hi_r;
  assign LO = lo_r;

  // Sequencer: issue in IDLE, count down in RUN, commit on the final busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      pending_hi_r <= 32'd0;
      pending_lo_r <= 32'd0;
      pending_wr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (MDUop)
              OP_MULT, OP_MULTU: begin
                pending_wr_r <= result_s[64];
                pending_hi_r <= result_s[63:32];
                pending_lo_r <= result_s[31:0];
                cnt_r        <= 4'(MULT_CYCLES);
                state_r      <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pending_wr_r <= result_s[64];
                pending_hi_r <= result_s[63:32];
                pending_lo_r <= result_s[31:0];
                cnt_r        <= 4'(DIV_CYCLES);
                state_r      <= RUN;
              end
              OP_MTHI: hi_r <= A;
              OP_MTLO: lo_r <= A;
              default: state_r <= IDLE;
            endcase
          end
        end
        RUN: begin
          if (cnt_r == 4'd1) begin
            if (pending_wr_r) begin
              hi_r <= pending_hi_r;
              lo_r <= pending_lo_r;
            end
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed test-plan cases plus random ops,
// checked against a plain-arithmetic HI/LO reference model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUop;
  logic        start;
  logic        flush;
  logic        rd_hi;
  logic        busy;
  logic        md_hazard;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop), .start(start),
    .flush(flush), .rd_hi(rd_hi), .busy(busy), .md_hazard(md_hazard),
    .HI(HI), .LO(LO), .MDUout(MDUout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: 64-bit integer arithmetic, truncating division, remainder takes dividend sign.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output bit wr);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    h  = 32'd0;
    l  = 32'd0;
    case (op)
      3'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd4: begin
        if (b == 32'd0) wr = 1'b0;
        else begin l = a / b; h = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // Monitor: counts busy cycles, checks md_hazard, pops the scoreboard when busy drops.
  int run_len = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy === 1'b1) begin
      run_len++;
      chk("md_hazard_busy", 32'(md_hazard), 32'd1);
    end else begin
      chk("md_hazard_idle", 32'(md_hazard),
          32'(start && (MDUop >= 3'd1) && (MDUop <= 3'd4) && !flush));
      if (prev_busy) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("busy_len", 32'(run_len), 32'(e.n));
          chk("hi_commit", HI, e.hi);
          chk("lo_commit", LO, e.lo);
          chk("mduout_commit", MDUout, rd_hi ? e.hi : e.lo);
        end
      end
      run_len = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // inject: 0 none, 1 mtlo start at busy cycle 2, 2 flush at busy cycle 2, 3 reset at busy cycle 3
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
    logic [31:0] h, l;
    bit          wr;
    exp_t        e;
    int          n;
    ref_md(op, a, b, h, l, wr);
    n = (op <= 3'd2) ? MC : DC;
    start = 1'b1; flush = 1'b0; MDUop = op; A = a; B = b; rd_hi = 1'($urandom);
    cyc();
    start = 1'b0; MDUop = 3'($urandom); A = $urandom; B = $urandom; rd_hi = 1'($urandom);
    if (inject == 3) begin
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      e.n = 3; e.hi = 32'd0; e.lo = 32'd0;
      sb_q.push_back(e);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
    end else begin
      if (wr) begin
        m_hi = h;
        m_lo = l;
      end
      e.n = n; e.hi = m_hi; e.lo = m_lo;
      sb_q.push_back(e);
      for (int i = 1; i <= n; i++) begin
        if (i == 2 && inject == 1) begin start = 1'b1; MDUop = 3'd6; A = 32'h55; end
        if (i == 2 && inject == 2) flush = 1'b1;
        cyc();
        start = 1'b0;
        flush = 1'b0;
      end
    end
  endtask

  task automatic run_simple(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; flush = 1'b0; MDUop = op; A = a;
    cyc();
    start = 1'b0;
    if (op == 3'd5) m_hi = a;
    else if (op == 3'd6) m_lo = a;
    chk("simple_busy", 32'(busy), 32'd0);
    chk("simple_hi", HI, m_hi);
    chk("simple_lo", LO, m_lo);
    rd_hi = 1'b0; #1;
    chk("mduout_lo", MDUout, m_lo);
    rd_hi = 1'b1; #1;
    chk("mduout_hi", MDUout, m_hi);
  endtask

  task automatic flush_issue(input logic [2:0] op);
    start = 1'b1; flush = 1'b1; MDUop = op; A = $urandom; B = $urandom;
    cyc();
    start = 1'b0; flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", HI, m_hi);
    chk("flush_lo", LO, m_lo);
  endtask

  function automatic logic [31:0] pick_operand(input int zero_ok);
    int k;
    k = int'($urandom_range(0, 7));
    case (k)
      0: return (zero_ok != 0) ? 32'd0 : 32'd3;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int r;
    reset = 1'b1; start = 1'b0; flush = 1'b0; A = 32'd0; B = 32'd0; MDUop = 3'd0; rd_hi = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_hi", HI, 32'd0);
    chk("init_lo", LO, 32'd0);

    run_md(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_simple(3'd5, 32'h1234_5678);
    run_simple(3'd6, 32'd0);
    run_md(3'd4, 32'd5, 32'd0, 0);
    run_simple(3'd6, 32'hAA);
    run_md(3'd1, 32'hFFFF_FFF0, 32'd1000, 1);
    flush_issue(3'd1);
    run_md(3'd1, 32'h0001_0000, 32'h0001_0000, 2);
    run_md(3'd3, 32'd100, 32'd7, 3);
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 0);

    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) run_md(3'($urandom_range(1, 4)), pick_operand(1), pick_operand(1), 0);
      else if (r == 6) run_simple(3'($urandom_range(5, 6)), $urandom);
      else if (r == 7) flush_issue(3'($urandom_range(1, 6)));
      else if (r == 8) run_simple(($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7, $urandom);
      else run_md(3'($urandom_range(1, 4)), pick_operand(0), pick_operand(1), int'($urandom_range(1, 3)));
    end

    cyc();
    cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
